// File: rtl/bcd_3digit_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd_3digit_to_binary_seq_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Width of one packed BCD digit.
    localparam int DIGIT_W = 4;

    // Largest legal value of a BCD digit.
    localparam int BCD_MAX_DIGIT = 9;

    // Width of a counter that must be able to hold the value bin_w.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_3digit_to_binary_seq_sub3.sv
// Per-digit reverse double-dabble adjust: digits of 8 or more lose 3.
module bcd_digit_sub3
    import bcd_3digit_to_binary_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    // Only digits >= 8 are adjusted, so the subtraction cannot underflow.
    assign adjusted = (digit >= DIGIT_W'(8)) ? digit - DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_3digit_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double dabble),
// one result bit per clock, with a start/busy/done handshake.
module bcd_3digit_to_binary_seq
    import bcd_3digit_to_binary_seq_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    output logic                        busy,
    output logic                        done,
    output logic [BIN_W-1:0]            bin_out,
    output logic                        err
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t            state;
    state_t            state_next;
    logic              do_load;
    logic              do_shift;
    logic              do_finish;

    logic [BCD_W-1:0]  bcd_reg;
    logic [BIN_W-1:0]  bin_reg;
    logic [CNT_W-1:0]  cnt;
    logic              inv;

    logic [BCD_W-1:0]  bcd_shift;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BIN_W-1:0]  bin_shift;
    logic              any_bad;
    logic              ovf;

    // {bcd_reg, bin_reg} shifted right by one as a single register.
    assign bcd_shift = bcd_reg >> 1;
    assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

    // Anything left in the BCD register after all shifts means the value
    // does not fit in BIN_W bits.
    assign ovf = |bcd_reg;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_sub3 u_sub3 (
                .digit    (bcd_shift[g*DIGIT_W +: DIGIT_W]),
                .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Flag any incoming nibble that is not a decimal digit.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX_DIGIT)) begin
                any_bad = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    do_load    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                do_finish  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, iteration counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            inv     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
        end else begin
            done <= 1'b0;
            if (do_load) begin
                bcd_reg <= bcd_in;
                bin_reg <= '0;
                inv     <= any_bad;
                cnt     <= '0;
                busy    <= 1'b1;
            end
            if (do_shift) begin
                bcd_reg <= bcd_adj;
                bin_reg <= bin_shift;
                cnt     <= cnt + CNT_W'(1);
            end
            if (do_finish) begin
                err     <= inv | ovf;
                bin_out <= (inv | ovf) ? '0 : bin_reg;
                done    <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

endmodule
